// File: rtl/scurve_pkg.sv
// Shared state encoding, default timing and counter helpers for the S-curve trigger counter.
package scurve_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PULSE    = 3'd1,
      ST_RAZ      = 3'd2,
      ST_GAP      = 3'd3,
      ST_WR_PULSE = 3'd4,
      ST_WR_TRIG  = 3'd5,
      ST_DONE     = 3'd6
   } scurve_state_e;

   localparam int unsigned DEF_PULSE_PERIOD = 2000;
   localparam int unsigned DEF_PULSE_WIDTH  = 40;
   localparam int unsigned DEF_WINDOW       = 200;
   localparam int unsigned DEF_RAZ_WIDTH    = 8;
   localparam int unsigned DEF_SYNC_STAGES  = 2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/scurve_trigger_counter_if.sv
// FIFO write port between the S-curve trigger counter (master) and the data FIFO (slave).
interface scurve_trigger_counter_if;

   logic [15:0] Fifo_Din;
   logic        Fifo_Wr_En;
   logic        Fifo_Full;

   modport master (output Fifo_Din, output Fifo_Wr_En, input Fifo_Full);
   modport slave  (input Fifo_Din, input Fifo_Wr_En, output Fifo_Full);

endinterface

// File: rtl/trigger_sync_edge.sv
// Synchronises the OR of the discriminator outputs and emits a registered one-cycle
// pulse on each rising edge, SYNC_STAGES+1 cycles after the pin edge.
module trigger_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [2:0] trig_i,
   output logic       edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;
   logic                   edge_q;

   always_ff @(posedge Clk) begin
      if (reset) begin
         sync_q <= '0;
         last_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], |trig_i};
         last_q <= sync_q[SYNC_STAGES-1];
         edge_q <= sync_q[SYNC_STAGES-1] & ~last_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/scurve_trigger_counter.sv
// Single-DAC-point S-curve engine: fires CPT_MAX injection pulses, counts windowed triggers,
// writes pulse/trigger counts to the FIFO. Define SCURVE_MULTI_HIT_EN to count every edge in a window.
module scurve_trigger_counter
   import scurve_pkg::*;
#(
   parameter int unsigned PULSE_PERIOD = DEF_PULSE_PERIOD,
   parameter int unsigned PULSE_WIDTH  = DEF_PULSE_WIDTH,
   parameter int unsigned WINDOW       = DEF_WINDOW,
   parameter int unsigned RAZ_WIDTH    = DEF_RAZ_WIDTH,
   parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
   input  logic                      Clk,
   input  logic                      reset,
   input  logic                      Single_Test_Start,
   input  logic [15:0]               CPT_MAX,
   input  logic [2:0]                Trigger_In,
   output logic                      CTest_Pulse,
   output logic                      Raz_Chn,
   scurve_trigger_counter_if.master  fifo,
   output logic                      Single_Test_Done,
   output logic                      Busy
);

   localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
   localparam logic [15:0] RAZ_LAST = 16'(WINDOW + RAZ_WIDTH - 1);
   localparam logic [15:0] PER_LAST = 16'(PULSE_PERIOD - 1);
   localparam logic [15:0] PW_CNT   = 16'(PULSE_WIDTH);

   scurve_state_e state_q;
   logic [15:0]   per_q;
   logic [15:0]   cpt_q;
   logic [15:0]   pulse_q;
   logic [15:0]   trig_q;
   logic          hit_q;
   logic          ctest_q;
   logic          raz_q;
   logic [15:0]   din_q;
   logic          wr_q;
   logic          done_q;
   logic          busy_q;
   logic          edge_s;

   trigger_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .Clk    (Clk),
      .reset  (reset),
      .trig_i (Trigger_In),
      .edge_o (edge_s)
   );

   // Control FSM; every output is registered and aligned with the state it belongs to.
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         per_q   <= 16'd0;
         cpt_q   <= 16'd0;
         pulse_q <= 16'd0;
         trig_q  <= 16'd0;
         hit_q   <= 1'b0;
         ctest_q <= 1'b0;
         raz_q   <= 1'b0;
         din_q   <= 16'd0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         wr_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (Single_Test_Start) begin
                  cpt_q   <= CPT_MAX;
                  pulse_q <= 16'd0;
                  trig_q  <= 16'd0;
                  hit_q   <= 1'b0;
                  per_q   <= 16'd0;
                  busy_q  <= 1'b1;
                  if (CPT_MAX == 16'd0) begin
                     din_q   <= 16'd0;
                     state_q <= ST_WR_PULSE;
                  end else begin
                     ctest_q <= 1'b1;
                     state_q <= ST_PULSE;
                  end
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ST_PULSE: begin
               if (edge_s) begin
`ifdef SCURVE_MULTI_HIT_EN
                  trig_q <= sat_inc16(trig_q);
`else
                  if (!hit_q) begin
                     trig_q <= sat_inc16(trig_q);
                     hit_q  <= 1'b1;
                  end else begin
                     trig_q <= trig_q;
                  end
`endif
               end else begin
                  trig_q <= trig_q;
               end
               per_q <= per_q + 16'd1;
               // A late edge on the final window cycle is counted above before hit_q is cleared here.
               if (per_q == WIN_LAST) begin
                  pulse_q <= pulse_q + 16'd1;
                  hit_q   <= 1'b0;
                  ctest_q <= 1'b0;
                  raz_q   <= 1'b1;
                  state_q <= ST_RAZ;
               end else begin
                  ctest_q <= ((per_q + 16'd1) < PW_CNT);
               end
            end
            ST_RAZ: begin
               per_q <= per_q + 16'd1;
               if (per_q == RAZ_LAST) begin
                  raz_q   <= 1'b0;
                  state_q <= ST_GAP;
               end else begin
                  raz_q <= 1'b1;
               end
            end
            ST_GAP: begin
               if (per_q == PER_LAST) begin
                  per_q <= 16'd0;
                  if (pulse_q == cpt_q) begin
                     din_q   <= pulse_q;
                     state_q <= ST_WR_PULSE;
                  end else begin
                     ctest_q <= 1'b1;
                     state_q <= ST_PULSE;
                  end
               end else begin
                  per_q <= per_q + 16'd1;
               end
            end
            ST_WR_PULSE: begin
               if (!fifo.Fifo_Full) begin
                  wr_q    <= 1'b1;
                  state_q <= ST_WR_TRIG;
               end else begin
                  wr_q <= 1'b0;
               end
            end
            ST_WR_TRIG: begin
               din_q <= trig_q;
               if (!fifo.Fifo_Full) begin
                  wr_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  wr_q <= 1'b0;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               ctest_q <= 1'b0;
               raz_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign CTest_Pulse      = ctest_q;
   assign Raz_Chn          = raz_q;
   assign fifo.Fifo_Din    = din_q;
   assign fifo.Fifo_Wr_En  = wr_q;
   assign Single_Test_Done = done_q;
   assign Busy             = busy_q;

endmodule

// File: tb/tb_scurve_trigger_counter.sv
// Scoreboard bench: stimulus pushes expected FIFO words, a monitor pops them on every write.
module tb_scurve_trigger_counter;

   localparam int P  = 60;
   localparam int PW = 5;
   localparam int W  = 20;
   localparam int R  = 4;

   logic        Clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] cpt_max = 16'd0;
   logic [2:0]  trig = 3'd0;
   logic        ctest, raz, done, busy;

   scurve_trigger_counter_if fifo ();

   scurve_trigger_counter #(
      .PULSE_PERIOD (P),
      .PULSE_WIDTH  (PW),
      .WINDOW       (W),
      .RAZ_WIDTH    (R),
      .SYNC_STAGES  (2)
   ) dut (
      .Clk               (Clk),
      .reset             (reset),
      .Single_Test_Start (start),
      .CPT_MAX           (cpt_max),
      .Trigger_In        (trig),
      .CTest_Pulse       (ctest),
      .Raz_Chn           (raz),
      .fifo              (fifo),
      .Single_Test_Done  (done),
      .Busy              (busy)
   );

   always #5 Clk = ~Clk;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          ctest_edges = 0;
   int          done_cnt = 0;
   int          wr_cnt = 0;
   logic        ctest_prev = 1'b0;
   logic [15:0] exp_q[$];

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on each FIFO write and tallies pulses and done strobes.
   initial begin : monitor
      logic [15:0] e;
      forever begin
         @(negedge Clk);
         if (fifo.Fifo_Wr_En) begin
            wr_cnt++;
            chk("wr_while_full", int'(fifo.Fifo_Full), 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got din=%0d, expected no write", fifo.Fifo_Din);
            end else begin
               e = exp_q.pop_front();
               chk("fifo_word", int'(fifo.Fifo_Din), int'(e));
            end
         end
         if (ctest && !ctest_prev) ctest_edges++;
         ctest_prev = ctest;
         if (done) done_cnt++;
      end
   end

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctest"}, int'(ctest), 0);
      chk({tag, "_raz"},   int'(raz), 0);
      chk({tag, "_wr"},    int'(fifo.Fifo_Wr_En), 0);
      chk({tag, "_din"},   int'(fifo.Fifo_Din), 0);
      chk({tag, "_done"},  int'(done), 0);
      chk({tag, "_busy"},  int'(busy), 0);
   endtask

   task automatic wait_ctest();
      for (int n = 0; n < 2 * P && !ctest; n++) tick();
      if (!ctest) chk("ctest_timeout", 0, 1);
   endtask

   task automatic run_test(input int cpt, input int kfix, input bit gap_trig,
                           input int full_hold, input bit mid_start);
      int e0, d0, c0, k, off, exp_trig;
      exp_trig = 0;
      e0 = ctest_edges;
      d0 = done_cnt;
      exp_q.push_back(16'(cpt));
      if (full_hold > 0) fifo.Fifo_Full = 1'b1;
      cpt_max = 16'(cpt);
      start = 1'b1;
      tick();
      start = 1'b0;
      cpt_max = 16'($urandom);
      c0 = cyc;
      for (int i = 0; i < cpt; i++) begin
         wait_ctest();
         off = 0;
         k = (kfix >= 0) ? kfix : int'($urandom_range(0, 3));
`ifdef SCURVE_MULTI_HIT_EN
         exp_trig += k;
`else
         exp_trig += (k > 0) ? 1 : 0;
`endif
         for (int j = 0; j < k; j++) begin
            tick(); off++;
            trig = 3'($urandom_range(1, 7));
            tick(); off++;
            tick(); off++;
            trig = 3'd0;
            tick(); off++;
         end
         if (gap_trig) begin
            while (off < 28) begin tick(); off++; end
            trig = 3'($urandom_range(1, 7));
            tick(); off++;
            tick(); off++;
            trig = 3'd0;
         end
         if (mid_start && i == 0) begin
            while (off < 40) begin tick(); off++; end
            cpt_max = 16'd9;
            start = 1'b1;
            tick(); off++;
            start = 1'b0;
         end
         while (off < 33) begin tick(); off++; end
      end
      exp_q.push_back(16'(exp_trig));
      if (full_hold > 0) begin
         while (cyc < c0 + cpt * P + 5) tick();
         for (int n = 0; n < 5; n++) begin
            chk("din_held", int'(fifo.Fifo_Din), cpt);
            tick();
         end
         fifo.Fifo_Full = 1'b0;
         tick();
         chk("wr_after_full", int'(fifo.Fifo_Wr_En), 1);
      end
      for (int n = 0; n < 3 * P + 50 && done_cnt == d0; n++) tick();
      chk("done_pulses", done_cnt - d0, 1);
      chk("ctest_pulses", ctest_edges - e0, cpt);
      tick();
      chk("busy_after", int'(busy), 0);
      chk("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int w0, d0;
      fifo.Fifo_Full = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      run_test(4, 1, 1'b0, 0, 1'b0);
      run_test(3, 0, 1'b1, 0, 1'b0);
      run_test(2, -1, 1'b0, 10, 1'b0);
      run_test(0, 0, 1'b0, 0, 1'b0);
      run_test(2, 3, 1'b0, 0, 1'b0);

      // Abort during the second pulse of a five-pulse test.
      w0 = wr_cnt;
      d0 = done_cnt;
      cpt_max = 16'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_ctest();
      repeat (10) tick();
      wait_ctest();
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk_all_zero("abort");
      reset = 1'b0;
      repeat (3 * P) tick();
      chk("abort_no_write", wr_cnt - w0, 0);
      chk("abort_no_done", done_cnt - d0, 0);
      run_test(5, 1, 1'b0, 0, 1'b0);

      for (int t = 0; t < 4; t++) begin
         run_test(int'($urandom_range(1, 5)), -1, 1'($urandom_range(0, 1)), 0, (t == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scurve_trigger_counter.md
Name: scurve_trigger_counter

Overview:
Single-DAC-point S-curve engine that sits directly upstream of the S-curve test controller.
- On a start pulse it fires CPT_MAX charge-injection pulses and counts the discriminator triggers seen inside a window after each pulse.
- It then writes the pulse count and the trigger count into the S-curve data FIFO and signals done.
- The controller drains that FIFO toward USB and steps the next DAC code.

Parameters:
PULSE_PERIOD, 2000, cycles from one CTest_Pulse rising edge to the next; must exceed WINDOW+RAZ_WIDTH+2.
PULSE_WIDTH, 40, cycles CTest_Pulse stays high; must be <= WINDOW.
WINDOW, 200, cycles the trigger window stays open, starting at the pulse rising edge.
RAZ_WIDTH, 8, cycles Raz_Chn is held high after each window.
SYNC_STAGES, 2, flip-flop stages in the trigger synchroniser; must be >= 2.

Ports:
Clk  in  1  system clock
reset  in  1  synchronous, active-high reset
Single_Test_Start  in  1  one-cycle start pulse; ignored unless in IDLE
CPT_MAX  in  16  number of injection pulses; latched at start
Trigger_In  in  3  asynchronous discriminator outputs of the tested channel; OR-ed together
CTest_Pulse  out  1  charge-injection pulse to the ASIC
Raz_Chn  out  1  trigger-latch reset to the ASIC
Fifo_Din  out  16  FIFO write data
Fifo_Wr_En  out  1  FIFO write strobe
Fifo_Full  in  1  FIFO full flag
Single_Test_Done  out  1  one-cycle done pulse
Busy  out  1  high in every state except IDLE

Behaviour:
- Reset: synchronous, active-high. All outputs are 0, all counters are 0, state is IDLE. Reset asserted mid-test aborts immediately: no FIFO write, no done pulse.
- Trigger path: Trigger_In OR-reduced → SYNC_STAGES flip-flops → rising-edge detect. The edge is visible SYNC_STAGES+1 cycles after the pin edge. Edge detection always runs; edges are counted only inside the window.
- IDLE: on Single_Test_Start, latch CPT_MAX and clear pulse_cnt and trig_cnt. If CPT_MAX==0 go to WR_PULSE, otherwise go to PULSE.
- PULSE: CTest_Pulse=1 for cycles 0..PULSE_WIDTH-1 of the period; the period counter starts at 0 on entry. Window is open for cycles 0..WINDOW-1.
  - First window edge sets hit_flag and increments trig_cnt; later edges in the same window are ignored.
  - At cycle WINDOW-1: pulse_cnt++, clear hit_flag, go to RAZ.
- RAZ: Raz_Chn=1 for RAZ_WIDTH cycles, then go to GAP.
- GAP: wait until the period counter reaches PULSE_PERIOD-1. Then go to WR_PULSE if pulse_cnt==cpt_max, else go back to PULSE (period counter reset to 0).
- WR_PULSE: Fifo_Din=pulse_cnt. Fifo_Wr_En=1 for exactly one cycle, only in a cycle where Fifo_Full==0; Fifo_Din is held stable while Fifo_Full==1. After the write go to WR_TRIG.
- WR_TRIG: same write rules with Fifo_Din=trig_cnt, then go to DONE.
- DONE: Single_Test_Done=1 for one cycle, then go to IDLE.
- Counter widths: 16 bits. trig_cnt cannot exceed pulse_cnt in single-hit mode. Period counter is 16 bits.
- Simultaneous events: Single_Test_Start while Busy is ignored. A trigger edge on the last window cycle is counted. A trigger edge during RAZ or GAP is discarded.

Optional Feature:
SCURVE_MULTI_HIT_EN
- Defined: every synchronised rising edge inside the window increments trig_cnt, with no per-window limit; trig_cnt saturates at 16'hFFFF.
- Undefined: at most one count per window (hit_flag behaviour above).

Decomposition:
- Package scurve_pkg: state enumeration (IDLE, PULSE, RAZ, GAP, WR_PULSE, WR_TRIG, DONE) and default timing constants.
- Sub-module trigger_sync_edge: SYNC_STAGES synchroniser plus rising-edge detector; output is a 1-cycle pulse.

Test Plan:
- CPT_MAX=4, one Trigger_In pulse per window → exactly 4 CTest pulses; FIFO gets 0x0004 then 0x0004; one Single_Test_Done pulse; Busy returns to 0.
- CPT_MAX=3, no triggers, plus a trigger during each GAP → FIFO gets 0x0003 then 0x0000.
- CPT_MAX=2, Fifo_Full=1 for 10 cycles on entry to WR_PULSE → no Fifo_Wr_En while full; Din=0x0002 stays stable; the write happens the cycle after Full drops.
- CPT_MAX=0 → no CTest_Pulse; FIFO gets 0x0000, 0x0000; done pulse follows.
- CPT_MAX=2, 3 edges per window → trig word 0x0002 without SCURVE_MULTI_HIT_EN, 0x0006 with it.
- Reset asserted during the second pulse of CPT_MAX=5 → all outputs 0 next cycle; no FIFO write; a new start afterwards gives a clean 0x0005/count result.
